// File: rtl/backplane_clock_tx.sv
// backplane_clock_tx: free-running square wave on the backplane clock line,
// with an optional sync marker (one extended high phase) inserted on request.
// All outputs are registered. They are decoded from the state held in the
// previous cycle, so ext_clk and its strobes trail the phase state by one edge.
module backplane_clock_tx #(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned SYNC_HIGH   = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sync_req,
  output logic        ext_clk,
  output logic        rise,
  output logic        fall,
  output logic        sync_pending,
  output logic        sync_done,
  output logic [15:0] sync_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_SYNC
  } state_t;

  localparam logic [7:0] HP_M1 = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] SH_M1 = 8'(SYNC_HIGH - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        w_take_sync;
  logic        w_hi;
  logic        w_done;

  logic        r_ext_clk;
  logic        r_rise;
  logic        r_fall;
  logic        r_pending;
  logic        r_in_sync;
  logic        r_done;
  logic [15:0] r_count;

  // Phase state and down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next phase: a phase ends when the counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take_sync = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = HP_M1;
        end
      end
      S_LOW: begin
        if (r_cnt == '0) begin
          if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_pending) begin
            w_state_nxt = S_SYNC;
            w_cnt_nxt   = SH_M1;
            w_take_sync = 1'b1;
          end else begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = HP_M1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HIGH, S_SYNC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = HP_M1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: line level per phase, marker completion on the first low after SYNC.
  always_comb begin
    w_hi   = (r_state == S_HIGH) || (r_state == S_SYNC);
    w_done = (r_state == S_LOW) && r_in_sync;
  end

  // Registered line, edge strobes, marker completion and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext_clk <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_in_sync <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_ext_clk <= w_hi;
      r_rise    <= w_hi & ~r_ext_clk;
      r_fall    <= ~w_hi & r_ext_clk;
      r_in_sync <= (r_state == S_SYNC);
      r_done    <= w_done;
      if (w_done) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  // Single-entry request latch; a new request wins over the clear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (sync_req) begin
      r_pending <= 1'b1;
    end else if (w_take_sync) begin
      r_pending <= 1'b0;
    end
  end

  assign ext_clk      = r_ext_clk;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign sync_pending = r_pending;
  assign sync_done    = r_done;
  assign sync_count   = r_count;

endmodule

// File: tb/tb_backplane_clock_tx.sv
// Directed bench for backplane_clock_tx with default parameters (8 / 160).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_backplane_clock_tx;

  localparam int HP    = 8;
  localparam int SH    = 160;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sync_req;
  logic        ext_clk;
  logic        rise;
  logic        fall;
  logic        sync_pending;
  logic        sync_done;
  logic [15:0] sync_count;

  int checks   = 0;
  int failures = 0;
  int exp_markers = 0;

  always #5 clk = ~clk;

  backplane_clock_tx #(.HALF_PERIOD(HP), .SYNC_HIGH(SH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sync_req     (sync_req),
    .ext_clk      (ext_clk),
    .rise         (rise),
    .fall         (fall),
    .sync_pending (sync_pending),
    .sync_done    (sync_done),
    .sync_count   (sync_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Ticks until the requested strobe is seen; n = ticks taken (LIMIT on expiry).
  task automatic wait_edge(input bit want_rise, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(want_rise ? (rise === 1'b1) : (fall === 1'b1)) && n < LIMIT);
  endtask

  // Counts consecutive samples at level lvl starting with the current one.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (ext_clk === lvl && n < LIMIT) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; sync_req = 1'b0;
    tick(); tick();
    checks++;
    if ({ext_clk, rise, fall, sync_pending, sync_done, sync_count} !== 21'd0) begin
      failures++;
      $display("FAIL reset_values: got %h expected 0", {ext_clk, rise, fall, sync_pending, sync_done, sync_count});
    end
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (ext_clk !== 1'b0 || rise !== 1'b0 || sync_pending !== 1'b0) begin
      failures++;
      $display("FAIL idle_disabled: got ext=%b rise=%b pend=%b expected 0 0 0", ext_clk, rise, sync_pending);
    end
  endtask

  task automatic test_freerun();
    int n, nr, nf, bad, run, maxrun;
    logic prev;
    enable = 1'b1;
    wait_edge(1'b1, n);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL enable_latency: got %0d ticks expected 10", n);
    end
    nr = 1; nf = 0; bad = 0; run = 1; maxrun = 1; prev = ext_clk;
    for (int i = 1; i < 12 * 2 * HP; i++) begin
      tick();
      if (rise !== (ext_clk & ~prev)) bad++;
      if (fall !== (~ext_clk & prev)) bad++;
      if (sync_done !== 1'b0) bad++;
      if (ext_clk !== prev) begin
        if (run != HP) bad++;
        run = 1;
      end else begin
        run++;
      end
      if (run > maxrun) maxrun = run;
      if (rise === 1'b1) nr++;
      if (fall === 1'b1) nf++;
      prev = ext_clk;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL freerun_shape: got %0d bad samples expected 0", bad);
    end
    checks++;
    if (nr !== 12 || nf !== 12) begin
      failures++;
      $display("FAIL freerun_strobes: got rise=%0d fall=%0d expected 12 12", nr, nf);
    end
    checks++;
    if (maxrun !== HP) begin
      failures++;
      $display("FAIL freerun_max_high: got %0d expected %0d (below receiver threshold 128)", maxrun, HP);
    end
    checks++;
    if (sync_count !== 16'd0) begin
      failures++;
      $display("FAIL freerun_count: got %0d expected 0", sync_count);
    end
  endtask

  task automatic test_single_marker();
    int n;
    wait_edge(1'b1, n);
    checks++;
    if (n >= LIMIT) begin failures++; $display("FAIL single_wait_rise: got timeout expected rise"); end
    tick(); tick(); tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    checks++;
    if (sync_pending !== 1'b1) begin failures++; $display("FAIL single_pending_set: got %b expected 1", sync_pending); end
    measure(1'b1, n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL single_high_rest: got %0d expected 4", n); end
    checks++;
    if (sync_pending !== 1'b1) begin failures++; $display("FAIL single_pending_held: got %b expected 1", sync_pending); end
    measure(1'b0, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL single_low_before: got %0d expected %0d", n, HP); end
    checks++;
    if (rise !== 1'b1 || sync_pending !== 1'b0) begin
      failures++;
      $display("FAIL single_marker_start: got rise=%b pend=%b expected 1 0", rise, sync_pending);
    end
    measure(1'b1, n);
    checks++;
    if (n !== SH) begin failures++; $display("FAIL single_marker_len: got %0d expected %0d", n, SH); end
    exp_markers++;
    checks++;
    if (fall !== 1'b1 || sync_done !== 1'b1 || sync_count !== 16'(exp_markers)) begin
      failures++;
      $display("FAIL single_done: got fall=%b done=%b count=%0d expected 1 1 %0d", fall, sync_done, sync_count, exp_markers);
    end
    tick();
    checks++;
    if (sync_done !== 1'b0) begin failures++; $display("FAIL single_done_width: got %b expected 0", sync_done); end
    measure(1'b0, n);
    checks++;
    if (n !== HP - 1) begin failures++; $display("FAIL single_low_after: got %0d expected %0d", n, HP - 1); end
    measure(1'b1, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL single_resume_high: got %0d expected %0d", n, HP); end
    measure(1'b0, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL single_resume_low: got %0d expected %0d", n, HP); end
  endtask

  task automatic test_back_to_back();
    int n;
    wait_edge(1'b0, n);
    checks++;
    if (n >= LIMIT) begin failures++; $display("FAIL b2b_wait_fall: got timeout expected fall"); end
    sync_req = 1'b1; tick(); sync_req = 1'b0; tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0; tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    measure(1'b0, n);
    checks++;
    if (n !== 3) begin failures++; $display("FAIL b2b_low_rest: got %0d expected 3", n); end
    repeat (20) tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    measure(1'b1, n);
    checks++;
    if (n !== SH - 21) begin failures++; $display("FAIL b2b_marker1_rest: got %0d expected %0d", n, SH - 21); end
    exp_markers++;
    checks++;
    if (sync_count !== 16'(exp_markers) || sync_pending !== 1'b1) begin
      failures++;
      $display("FAIL b2b_after_first: got count=%0d pend=%b expected %0d 1", sync_count, sync_pending, exp_markers);
    end
    measure(1'b0, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL b2b_gap_low: got %0d expected %0d", n, HP); end
    measure(1'b1, n);
    checks++;
    if (n !== SH) begin failures++; $display("FAIL b2b_marker2_len: got %0d expected %0d", n, SH); end
    exp_markers++;
    measure(1'b0, n);
    measure(1'b1, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL b2b_no_third: got high %0d expected %0d", n, HP); end
    checks++;
    if (sync_count !== 16'(exp_markers) || sync_pending !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: got count=%0d pend=%b expected %0d 0", sync_count, sync_pending, exp_markers);
    end
  endtask

  task automatic test_late_request();
    int n;
    wait_edge(1'b0, n);
    checks++;
    if (n >= LIMIT) begin failures++; $display("FAIL late_wait_fall: got timeout expected fall"); end
    repeat (HP - 2) tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    measure(1'b0, n);
    checks++;
    if (n !== 1) begin failures++; $display("FAIL late_low_rest: got %0d expected 1", n); end
    measure(1'b1, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL late_normal_high: got %0d expected %0d", n, HP); end
    measure(1'b0, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL late_low: got %0d expected %0d", n, HP); end
    measure(1'b1, n);
    checks++;
    if (n !== SH) begin failures++; $display("FAIL late_marker_len: got %0d expected %0d", n, SH); end
    exp_markers++;
    checks++;
    if (sync_count !== 16'(exp_markers)) begin
      failures++;
      $display("FAIL late_count: got %0d expected %0d", sync_count, exp_markers);
    end
  endtask

  task automatic test_disable();
    int n, bad;
    wait_edge(1'b1, n);
    checks++;
    if (n >= LIMIT) begin failures++; $display("FAIL dis_wait_rise: got timeout expected rise"); end
    sync_req = 1'b1; tick(); sync_req = 1'b0; tick();
    enable = 1'b0; tick();
    measure(1'b1, n);
    checks++;
    if (n !== HP - 3) begin failures++; $display("FAIL dis_high_completes: got %0d expected %0d", n, HP - 3); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (ext_clk !== 1'b0 || rise !== 1'b0 || sync_pending !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL dis_parked: got %0d bad samples expected 0", bad); end
    enable = 1'b1;
    wait_edge(1'b1, n);
    checks++;
    if (n !== 10) begin failures++; $display("FAIL dis_reenable_latency: got %0d expected 10", n); end
    measure(1'b1, n);
    checks++;
    if (n !== SH) begin failures++; $display("FAIL dis_marker_len: got %0d expected %0d", n, SH); end
    exp_markers++;
    checks++;
    if (sync_count !== 16'(exp_markers) || sync_done !== 1'b1) begin
      failures++;
      $display("FAIL dis_count: got count=%0d done=%b expected %0d 1", sync_count, sync_done, exp_markers);
    end
  endtask

  task automatic test_reset_mid_sync();
    int n;
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    wait_edge(1'b1, n);
    checks++;
    if (n >= LIMIT) begin failures++; $display("FAIL rst_wait_rise: got timeout expected rise"); end
    repeat (49) tick();
    checks++;
    if (ext_clk !== 1'b1) begin failures++; $display("FAIL rst_in_marker: got ext=%b expected 1", ext_clk); end
    rst = 1'b0;
    #1;
    checks++;
    if ({ext_clk, rise, fall, sync_pending, sync_done, sync_count} !== 21'd0) begin
      failures++;
      $display("FAIL rst_async: got %h expected 0", {ext_clk, rise, fall, sync_pending, sync_done, sync_count});
    end
    tick(); tick();
    checks++;
    if ({ext_clk, sync_done, sync_count} !== 18'd0) begin
      failures++;
      $display("FAIL rst_held: got %h expected 0", {ext_clk, sync_done, sync_count});
    end
    rst = 1'b1;
    wait_edge(1'b1, n);
    checks++;
    if (n !== 10) begin failures++; $display("FAIL rst_resume_latency: got %0d expected 10", n); end
    measure(1'b1, n);
    checks++;
    if (n !== HP) begin failures++; $display("FAIL rst_resume_high: got %0d expected %0d", n, HP); end
    checks++;
    if (sync_count !== 16'd0 || sync_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_truncated_uncounted: got count=%0d done=%b expected 0 0", sync_count, sync_done);
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_single_marker();
    test_back_to_back();
    test_late_request();
    test_disable();
    test_reset_mid_sync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/backplane_clock_tx.md
# backplane_clock_tx

Transmit side of the backplane clock line: generates a free-running square-wave `ext_clk` from the fabric clock and, on request, inserts a sync marker, which is one extended high phase. The marker is long enough for the backplane receiver's high-duration detector to fire; normal high phases are too short to fire it. The block sits in the AXI-Lite peripheral next to the backplane reader and drives the same line the reader samples, for loopback test and for emulating a backplane master.

## Interface
- `HALF_PERIOD`, 8: fabric cycles per normal low or high phase; legal range 1..64, so a normal high never reaches the receiver's 0x80 threshold.
- `SYNC_HIGH`, 160: fabric cycles of the sync-marker high phase; legal range 130..255. Must exceed 0x80 with margin and fit the 8-bit phase counter.
- `clk` in 1: fabric clock; all logic is on its rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `enable` in 1: level; 1 = generate clock, 0 = park line low at the next low-phase end.
- `sync_req` in 1: one-cycle request to insert a sync marker.
- `ext_clk` out 1: registered backplane clock output.
- `rise` out 1: one-cycle strobe in the first cycle `ext_clk` is 1 after being 0.
- `fall` out 1: one-cycle strobe in the first cycle `ext_clk` is 0 after being 1.
- `sync_pending` out 1: a request is latched and not yet started.
- `sync_done` out 1: one-cycle strobe in the first low cycle after a marker.
- `sync_count` out 16: number of markers completed; wraps 0xFFFF to 0x0000.

## Operation
- **States:** IDLE, LOW, HIGH, SYNC. There is an 8-bit down-counter `cnt`. A phase ends in the cycle where `cnt == 0`.
- **IDLE:**
  - `ext_clk` = 0.
  - If `enable` = 1, go to LOW with `cnt` = HALF_PERIOD-1.
- **LOW:**
  - `ext_clk` = 0 for exactly HALF_PERIOD cycles.
  - At phase end, evaluate in priority order:
    - `enable` = 0: go to IDLE.
    - `sync_pending` = 1: go to SYNC with `cnt` = SYNC_HIGH-1, and clear pending.
    - Otherwise: go to HIGH with `cnt` = HALF_PERIOD-1.
- **HIGH:**
  - `ext_clk` = 1 for exactly HALF_PERIOD cycles.
  - At phase end, go to LOW. `enable` is not checked, so a high phase is never truncated.
- **SYNC:**
  - `ext_clk` = 1 for exactly SYNC_HIGH cycles.
  - At end, go to LOW with `cnt` = HALF_PERIOD-1. `sync_done` pulses in the first LOW cycle and `sync_count` increments in that same cycle.
- **Pending latch:**
  - `sync_req` = 1 sets `sync_pending` on the next edge.
  - A request while already pending is absorbed; there is no queue depth beyond 1.
  - A request during SYNC is latched and served at the end of the following LOW phase.
  - The phase-end decision uses only the registered `sync_pending`. A `sync_req` arriving in the final LOW cycle is therefore served at the next LOW end.
- **Disable with a pending request:** pending is retained through IDLE and served at the end of the first LOW phase after re-enable.
- **Strobes:** `rise` and `fall` are registered alongside `ext_clk`. A SYNC entry produces `rise`; a SYNC exit produces `fall`.
- **Reset values:** state IDLE, `cnt` 0, `ext_clk` 0, `rise` 0, `fall` 0, `sync_pending` 0, `sync_done` 0, `sync_count` 0x0000.

## Timing
- **Enable latency:** `enable` sampled 1 in IDLE at edge k; LOW begins at k+1. The first `rise` occurs at k+1+HALF_PERIOD.
- **Free-run period:** 2·HALF_PERIOD cycles with 50% duty.
- **Marker period:** a marker cycle lasts SYNC_HIGH + HALF_PERIOD cycles (high then low).
- **Output alignment:** all outputs are registered, with zero combinational input-to-output paths. `rise` and `fall` coincide with the `ext_clk` transition cycle.
- **Reset mid-operation:** asserting `rst` forces `ext_clk` low immediately (asynchronously), including mid-SYNC. A truncated marker is neither counted nor followed by `sync_done`. After deassertion, operation resumes from IDLE.

## Test plan
- **Reset:** assert `rst`=0 mid-SYNC at cycle 50 of the marker -> `ext_clk`, `sync_pending`, `sync_done`, `rise`, `fall` all 0 and `sync_count`=0 before the next `clk` edge. After release with `enable`=1, the first `rise` comes 9 cycles after the enabling edge.
- **Free run (defaults):** `enable`=1 for 200 cycles -> `ext_clk` period 16, high 8 / low 8. Exactly one `rise` and one `fall` per period. A receiver instance on the same clock never asserts its output.
- **Single marker:** pulse `sync_req` mid-HIGH -> `sync_pending`=1 until the next LOW end. Then `ext_clk` is high for exactly 160 cycles, and the receiver output asserts from cycle 130 of the high. `sync_done` pulses once, `sync_count`=1, and normal toggling resumes with period 16.
- **Back-to-back requests:** pulse `sync_req` three times within one LOW phase, then once during SYNC -> exactly 2 markers, separated by one 8-cycle low. `sync_count`=2.
- **Late request:** `sync_req` in the final LOW cycle -> a normal 8-cycle HIGH first, then the marker at the next LOW end.
- **Disable:** drop `enable` at HIGH cycle 3 with a request pending -> the high completes (8 cycles), the low completes (8 cycles), then IDLE with `ext_clk`=0 and `sync_pending` still 1. Re-enable -> the marker starts after the first 8-cycle low.
